// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and codes for the mem-stage data-bus bridge: access-size codes,
// FSM state encoding and the wait-counter width.
package mem_bus_bridge_pkg;

    localparam int L_S_MODE_W = 3;

    localparam logic [L_S_MODE_W-1:0] L_S_BYTE   = 3'd0;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF   = 3'd1;
    localparam logic [L_S_MODE_W-1:0] L_S_WORD   = 3'd2;
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE_U = 3'd4;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF_U = 3'd5;

    localparam int MB_WAIT_W = 8;

    typedef enum logic [1:0] {
        MB_IDLE   = 2'd0,
        MB_REQ    = 2'd1,
        MB_WAIT_R = 2'd2
    } mb_state_t;

    // Access size in bytes; unsigned variants size like their signed twins, 0 = unknown.
    function automatic logic [2:0] ls_size(input logic [L_S_MODE_W-1:0] mode);
        logic [2:0] size;
        case (mode)
            L_S_BYTE, L_S_BYTE_U: size = 3'd1;
            L_S_HALF, L_S_HALF_U: size = 3'd2;
            L_S_WORD:             size = 3'd4;
            default:              size = 3'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_bus_bridge_lane_align.sv
// Combinational byte-lane steering: byte enables, write-data shift, read-data
// right-justification. MEM_BRIDGE_ALIGN_CHECK_EN enables misalignment detection.
module mem_lane_align
    import mem_bus_bridge_pkg::*;
#(
    parameter int W    = 32,
    parameter int BE_W = W / 8
) (
    input  logic [L_S_MODE_W-1:0] mode,
    input  logic [1:0]            a,
    input  logic [W-1:0]          s_data,
    input  logic [W-1:0]          bus_rdata,
    output logic [BE_W-1:0]       be,
    output logic [W-1:0]          wdata,
    output logic [W-1:0]          rdata_shifted,
    output logic                  misaligned
);

    logic [2:0] size;
    logic       is_word;
    logic [3:0] lane_lo;
    logic [3:0] lane_hi;
    logic [4:0] shamt;

    always_comb begin
        size    = ls_size(mode);
        is_word = (mode == L_S_WORD);
        lane_lo = {2'b00, a};
        lane_hi = lane_lo + {1'b0, size};
        shamt   = {a, 3'b000};
    end

    // Lanes past the top of the word simply fall off, so a half at a=3 keeps lane 3 only.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            assign be[gi] = is_word | ((4'(gi) >= lane_lo) && (4'(gi) < lane_hi));
        end
    endgenerate

    assign wdata         = s_data << shamt;
    assign rdata_shifted = bus_rdata >> shamt;

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    assign misaligned = (is_word && (a != 2'b00)) || ((size == 3'd2) && a[0]);
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_bus_bridge.sv
// Mem-stage load/store to req/gnt/rvalid data-bus bridge with pipeline stall and
// timeout abort. Optional MEM_BRIDGE_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int W        = 32,
    parameter int BE_W     = W / 8,
    parameter int MAX_WAIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [W-1:0]          l_addr,
    output logic [W-1:0]          l_data,
    input  logic                  store_en,
    input  logic [W-1:0]          s_addr,
    input  logic [W-1:0]          s_data,
    input  logic [L_S_MODE_W-1:0] l_s_mode,
    output logic                  stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [W-1:0]          bus_addr,
    output logic [BE_W-1:0]       bus_be,
    output logic [W-1:0]          bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [W-1:0]          bus_rdata,
    output logic                  bus_err,
    output logic                  misalign
);

    localparam logic [MB_WAIT_W-1:0] MAX_CNT = MB_WAIT_W'(MAX_WAIT);

    mb_state_t            state_reg;
    logic                 is_store_reg;
    logic [1:0]           a_reg;
    logic [MB_WAIT_W-1:0] wait_cnt_reg;

    logic                 req_any;
    logic [W-1:0]         req_addr;
    logic [1:0]           a_sel;
    logic [BE_W-1:0]      be_next;
    logic [W-1:0]         wdata_next;
    logic [W-1:0]         rdata_shifted;
    logic                 misaligned;

    // The store wins when both requests arrive together, so its address is steered.
    always_comb begin
        req_any  = load_en | store_en;
        req_addr = store_en ? s_addr : l_addr;
        a_sel    = (state_reg == MB_IDLE) ? req_addr[1:0] : a_reg;
        stall    = (state_reg != MB_IDLE) | req_any;
    end

    mem_lane_align #(
        .W    (W),
        .BE_W (BE_W)
    ) u_lane_align (
        .mode          (l_s_mode),
        .a             (a_sel),
        .s_data        (s_data),
        .bus_rdata     (bus_rdata),
        .be            (be_next),
        .wdata         (wdata_next),
        .rdata_shifted (rdata_shifted),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= MB_IDLE;
            is_store_reg <= 1'b0;
            a_reg        <= 2'b00;
            wait_cnt_reg <= '0;
            l_data       <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
            bus_err      <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            bus_err  <= 1'b0;
            misalign <= 1'b0;
            case (state_reg)
                MB_IDLE: begin
                    if (req_any) begin
                        bus_err <= load_en & store_en;
                        if (misaligned) begin
                            misalign <= 1'b1;
                        end else begin
                            bus_req      <= 1'b1;
                            bus_we       <= store_en;
                            bus_addr     <= {req_addr[W-1:2], 2'b00};
                            bus_be       <= be_next;
                            bus_wdata    <= store_en ? wdata_next : '0;
                            is_store_reg <= store_en;
                            a_reg        <= req_addr[1:0];
                            wait_cnt_reg <= '0;
                            state_reg    <= MB_REQ;
                        end
                    end
                end
                MB_REQ: begin
                    if (bus_gnt) begin
                        bus_req      <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= is_store_reg ? MB_IDLE : MB_WAIT_R;
                    end else if (wait_cnt_reg == MAX_CNT) begin
                        bus_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        state_reg <= MB_IDLE;
                        if (!is_store_reg) begin
                            l_data <= '0;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                MB_WAIT_R: begin
                    if (bus_rvalid) begin
                        l_data    <= rdata_shifted;
                        state_reg <= MB_IDLE;
                    end else if (wait_cnt_reg == MAX_CNT) begin
                        l_data    <= '0;
                        bus_err   <= 1'b1;
                        state_reg <= MB_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= MB_IDLE;
                    bus_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: directed accesses push expected bus
// handshakes and completion records; a negedge monitor pops and compares.
module tb_mem_bus_bridge;
    import mem_bus_bridge_pkg::*;

    localparam int MAXW = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en, store_en;
    logic [31:0] l_addr, s_addr, s_data, l_data;
    logic [2:0]  l_s_mode;
    logic        stall, bus_req, bus_we, bus_gnt, bus_rvalid, bus_err, misalign;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] ldata;
        int          err;
        int          mis;
        int          stall_cyc;
    } done_t;

    bus_t  bus_q[$];
    done_t done_q[$];
    int    exp_err = 0;
    int    exp_mis = 0;

    always #5 clk = ~clk;

    mem_bus_bridge #(.W(32), .BE_W(4), .MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .l_addr     (l_addr),
        .l_data     (l_data),
        .store_en   (store_en),
        .s_addr     (s_addr),
        .s_data     (s_data),
        .l_s_mode   (l_s_mode),
        .stall      (stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err),
        .misalign   (misalign)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endfunction

    function automatic void push_bus(input logic [31:0] addr, input logic we,
                                     input logic [3:0] be, input logic [31:0] wdata);
        bus_t b;
        b.addr = addr; b.we = we; b.be = be; b.wdata = wdata;
        bus_q.push_back(b);
    endfunction

    function automatic void push_done(input logic [31:0] ldata, input int stall_cyc);
        done_t d;
        d.ldata = ldata; d.err = exp_err; d.mis = exp_mis; d.stall_cyc = stall_cyc;
        done_q.push_back(d);
    endfunction

    // Monitor: bus handshakes and access completions (stall falling).
    initial begin
        int err_seen = 0;
        int mis_seen = 0;
        int run = 0;
        forever begin
            @(negedge clk);
            if (bus_err)  err_seen++;
            if (misalign) mis_seen++;
            if (bus_req && bus_gnt) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_handshake", 32'd1, 32'd0);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    chk("bus_addr", bus_addr, b.addr);
                    chk("bus_we", {31'd0, bus_we}, {31'd0, b.we});
                    chk("bus_be", {28'd0, bus_be}, {28'd0, b.be});
                    if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
                end
            end
            if (stall) begin
                run++;
            end else if (run > 0) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("l_data", l_data, d.ldata);
                    chk("bus_err_count", err_seen, d.err);
                    chk("misalign_count", mis_seen, d.mis);
                    chk("stall_cycles", run, d.stall_cyc);
                end
                run = 0;
            end
        end
    end

    task automatic access(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [2:0] mode, input logic [31:0] sd,
                          input logic grant, input int gdly, input int rdly,
                          input logic [31:0] rd);
        @(posedge clk); #1;
        load_en = ld; store_en = st; l_addr = addr; s_addr = addr;
        l_s_mode = mode; s_data = sd;
        @(posedge clk); #1;
        load_en = 1'b0; store_en = 1'b0;
        if (grant) begin
            repeat (gdly) begin @(posedge clk); #1; end
            bus_gnt = 1'b1;
            @(posedge clk); #1;
            bus_gnt = 1'b0;
            if (ld && !st) begin
                repeat (rdly) begin @(posedge clk); #1; end
                bus_rvalid = 1'b1; bus_rdata = rd;
                @(posedge clk); #1;
                bus_rvalid = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; load_en = 0; store_en = 0; l_addr = 0; s_addr = 0; s_data = 0;
        l_s_mode = L_S_WORD; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_l_data", l_data, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_err_mis", {30'd0, bus_err, misalign}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // LW 0x100: 3-cycle minimum load
        push_bus(32'h100, 1'b0, 4'b1111, 32'h0);
        push_done(32'hDEADBEEF, 3);
        access(1, 0, 32'h100, L_S_WORD, 32'h0, 1, 0, 0, 32'hDEADBEEF);

        // SB 0x103: posted store, 2 cycles
        push_bus(32'h100, 1'b1, 4'b1000, 32'hA5000000);
        push_done(32'hDEADBEEF, 2);
        access(0, 1, 32'h103, L_S_BYTE, 32'h000000A5, 1, 0, 0, 32'h0);

        // LH 0x102
        push_bus(32'h100, 1'b0, 4'b1100, 32'h0);
        push_done(32'h00008001, 3);
        access(1, 0, 32'h102, L_S_HALF, 32'h0, 1, 0, 0, 32'h80011234);

        // LBU 0x101 with gnt and rvalid delays: 1 + 3 + 4 stall cycles
        push_bus(32'h100, 1'b0, 4'b0010, 32'h0);
        push_done(32'h00AABBCC, 8);
        access(1, 0, 32'h101, L_S_BYTE_U, 32'h0, 1, 2, 3, 32'hAABBCCDD);

        // Load and store together: store wins, error pulse, l_data untouched
        exp_err++;
        push_bus(32'h200, 1'b1, 4'b1111, 32'h11223344);
        push_done(32'h00AABBCC, 2);
        access(1, 1, 32'h200, L_S_WORD, 32'h11223344, 1, 0, 0, 32'hFFFFFFFF);

        // Unknown mode still issued with no byte enables
        push_bus(32'h10, 1'b1, 4'b0000, 32'h000000FF);
        push_done(32'h00AABBCC, 2);
        access(0, 1, 32'h10, 3'd7, 32'h000000FF, 1, 0, 0, 32'h0);

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        exp_mis++;
        push_done(32'h00AABBCC, 1);
        access(0, 1, 32'h103, L_S_HALF, 32'h00001234, 0, 0, 0, 32'h0);
        exp_mis++;
        push_done(32'h00AABBCC, 1);
        access(1, 0, 32'h101, L_S_WORD, 32'h0, 0, 0, 0, 32'h0);
`else
        push_bus(32'h100, 1'b1, 4'b1000, 32'h34000000);
        push_done(32'h00AABBCC, 2);
        access(0, 1, 32'h103, L_S_HALF, 32'h00001234, 1, 0, 0, 32'h0);
`endif

        // Timeout: no gnt ever, aborts after MAXW+1 cycles in REQ
        exp_err++;
        push_done(32'h0, MAXW + 2);
        access(1, 0, 32'h300, L_S_WORD, 32'h0, 0, 0, 0, 32'h0);
        repeat (MAXW + 4) @(posedge clk);

        // Load 0x44 to make l_data nonzero, then reset in WAIT_R
        push_bus(32'h44, 1'b0, 4'b1111, 32'h0);
        push_done(32'h12345678, 3);
        access(1, 0, 32'h44, L_S_WORD, 32'h0, 1, 0, 0, 32'h12345678);
        push_bus(32'h40, 1'b0, 4'b1111, 32'h0);
        push_done(32'h0, 3);
        @(posedge clk); #1;
        load_en = 1'b1; l_addr = 32'h40; l_s_mode = L_S_WORD;
        @(posedge clk); #1;
        load_en = 1'b0; bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_l_data", l_data, 32'h0);
        chk("late_rvalid_bus_req", {31'd0, bus_req}, 32'd0);
        chk("late_rvalid_stall", {31'd0, stall}, 32'd0);
        repeat (3) @(posedge clk);

        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
